// File: rtl/logistic_multi_iter.sv
// ---------------------------------------------------------------------------
// logistic_multi_iter
//
// Runs CH independent logistic-map orbits x(n+1) = mu * x(n) * (1 - x(n)).
// All channels share one mu. x is unsigned Q0.W and mu is unsigned Q2.W.
// A run is started with a start/done handshake. Every intermediate sample
// x(0) .. x(times) is streamed out over a valid/ready port. A stalled
// consumer freezes the whole iteration, so no sample is dropped or repeated.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous reset, active low
//   start       run request, sampled only while idle
//   mu          map parameter (Q2.W), captured on accepted start
//   x0          initial values, channel c at [c*W +: W], captured on start
//   times       number of map applications, captured on accepted start
//   busy        high while iterating
//   done        one-cycle pulse when result is valid
//   result      final x(times) per channel, held until the next start
//   traj_valid  trajectory sample available (high while iterating)
//   traj_ready  consumer accepts the current sample
//   traj_data   current x(step), all channels
//   traj_step   index of traj_data
// ---------------------------------------------------------------------------
module logistic_multi_iter #(
    parameter int unsigned W     = 16,
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 9
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [W+1:0]        mu,
    input  logic [CH*W-1:0]     x0,
    input  logic [CNT_W-1:0]    times,
    output logic                busy,
    output logic                done,
    output logic [CH*W-1:0]     result,
    output logic                traj_valid,
    input  logic                traj_ready,
    output logic [CH*W-1:0]     traj_data,
    output logic [CNT_W-1:0]    traj_step
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [W+1:0]        mu_q, mu_d;
    logic [CNT_W-1:0]    times_q, times_d;
    logic [CNT_W-1:0]    step_q, step_d;
    logic [CH*W-1:0]     x_q, x_d;
    logic [CH*W-1:0]     result_q, result_d;
    logic [CH*W-1:0]     x_next;
    logic                handshake;

    // -----------------------------------------------------------------------
    // Map datapath: one full logistic step per channel, purely combinational.
    // -----------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_map
        logic [W-1:0]   x_c;
        logic [W:0]     one_minus_x;  // 2^W - x, needs W+1 bits for x = 0
        logic [2*W:0]   t;
        logic [W-1:0]   h;
        logic [2*W+1:0] p;
        logic           unused_bits;

        assign x_c         = x_q[c*W +: W];
        assign one_minus_x = {1'b1, {W{1'b0}}} - {1'b0, x_c};
        // x*(1-x) <= 2^(2W-2), so the top product bit is always zero.
        assign t           = {{(W+1){1'b0}}, x_c} * {{W{1'b0}}, one_minus_x};
        assign h           = t[2*W-1:W];
        // mu < 4 and h <= 0.25 keep p below 2^(2W): no saturation needed.
        assign p           = {{W{1'b0}}, mu_q} * {{(W+2){1'b0}}, h};
        assign x_next[c*W +: W] = p[2*W-1:W];

        // Truncated fraction bits and provably-zero integer bits.
        assign unused_bits = ^{t[2*W], t[W-1:0], p[2*W+1:2*W], p[W-1:0]};
    end

    assign handshake = (state_q == StRun) && traj_ready;

    // -----------------------------------------------------------------------
    // Next-state and datapath update.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mu_d     = mu_q;
        times_d  = times_q;
        step_d   = step_q;
        x_d      = x_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    mu_d    = mu;
                    times_d = times;
                    x_d     = x0;
                    step_d  = '0;
                end
            end
            StRun: begin
                if (handshake) begin
                    if (step_q == times_q) begin
                        // Last sample accepted: latch the orbit end points.
                        result_d = x_q;
                        state_d  = StDone;
                    end else begin
                        x_d    = x_next;
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mu_q     <= '0;
            times_q  <= '0;
            step_q   <= '0;
            x_q      <= '0;
            result_q <= '0;
        end else begin
            mu_q     <= mu_d;
            times_q  <= times_d;
            step_q   <= step_d;
            x_q      <= x_d;
            result_q <= result_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers or decodes of the registered state only.
    // -----------------------------------------------------------------------
    assign busy       = (state_q == StRun);
    assign traj_valid = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign result     = result_q;
    assign traj_data  = x_q;
    assign traj_step  = step_q;

endmodule

// File: tb/tb_logistic_multi_iter.sv
// ---------------------------------------------------------------------------
// tb_logistic_multi_iter
//
// Scoreboard bench for logistic_multi_iter. The driver computes each orbit
// with plain integer arithmetic and queues the expected samples and result.
// A monitor compares every presented sample and every done pulse against
// the queue fronts.
// ---------------------------------------------------------------------------
module tb_logistic_multi_iter;

    localparam int W     = 16;
    localparam int CH    = 4;
    localparam int CNT_W = 9;

    typedef struct {
        logic [CNT_W-1:0] step;
        logic [CH*W-1:0]  data;
    } samp_t;

    logic               CLK = 1'b0;
    logic               RST;
    logic               start;
    logic [W+1:0]       mu;
    logic [CH*W-1:0]    x0;
    logic [CNT_W-1:0]   times;
    logic               busy;
    logic               done;
    logic [CH*W-1:0]    result;
    logic               traj_valid;
    logic               traj_ready;
    logic [CH*W-1:0]    traj_data;
    logic [CNT_W-1:0]   traj_step;

    samp_t              exp_q[$];
    logic [CH*W-1:0]    res_q[$];
    int                 chk_cnt  = 0;
    int                 pass_cnt = 0;

    logistic_multi_iter #(
        .W     (W),
        .CH    (CH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .mu         (mu),
        .x0         (x0),
        .times      (times),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .traj_valid (traj_valid),
        .traj_ready (traj_ready),
        .traj_data  (traj_data),
        .traj_step  (traj_step)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: y = floor(mu * floor(x*(1-x)) ) in fixed point, plain integers.
    function automatic logic [W-1:0] f_map(input logic [W+1:0] m, input logic [W-1:0] x);
        longint unsigned one, xv, hv, pv;
        one = longint'(1) << W;
        xv  = longint'(x);
        hv  = (xv * (one - xv)) >> W;
        pv  = longint'(m) * hv;
        return W'(pv >> W);
    endfunction

    task automatic push_expect(input logic [W+1:0] m, input logic [CH*W-1:0] xs, input int tm);
        logic [CH*W-1:0] v;
        samp_t           s;
        v = xs;
        for (int n = 0; n <= tm; n++) begin
            s.step = CNT_W'(n);
            s.data = v;
            exp_q.push_back(s);
            if (n < tm) begin
                for (int c = 0; c < CH; c++) v[c*W +: W] = f_map(m, v[c*W +: W]);
            end
        end
        res_q.push_back(v);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        start = 1'b0;
        exp_q.delete();
        res_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge CLK) begin
        if (RST) begin
            if (traj_valid) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL traj_unexpected: got step %0d data %h, expected no sample",
                             traj_step, traj_data);
                end else begin
                    check("traj_step", 64'(traj_step), 64'(exp_q[0].step));
                    check("traj_data", traj_data, exp_q[0].data);
                    if (traj_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL done_unexpected: got done with result %h, expected none",
                             result);
                end else begin
                    check("result", result, res_q.pop_front());
                end
            end
        end
    end

    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles at step 1.
    task automatic run(input logic [W+1:0] m, input logic [CH*W-1:0] xs, input int tm,
                       input int mode, input bit glitch);
        int j;
        int stalls;
        int stall_left;
        bit got;
        push_expect(m, xs, tm);
        mu    = m;
        x0    = xs;
        times = CNT_W'(tm);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        mu    = (W+2)'($urandom_range(0, 32'h3FFFF));
        x0    = {$urandom, $urandom};
        times = CNT_W'($urandom);
        j = 1; stalls = 0; stall_left = 3; got = 1'b0;
        while (!got && j < 2000) begin
            case (mode)
                0: traj_ready = 1'b1;
                1: traj_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (traj_step == 1 && stall_left > 0) begin
                        traj_ready = 1'b0;
                        stall_left--;
                    end else begin
                        traj_ready = 1'b1;
                    end
                end
            endcase
            start = glitch && (j == 2);
            if (start) x0 = {$urandom, $urandom};
            @(negedge CLK);
            if (j == 1) begin
                check("busy_on", 64'(busy), 64'd1);
                check("valid_on", 64'(traj_valid), 64'd1);
            end
            if (done) begin
                got = 1'b1;
                check("done_latency", 64'(j), 64'(tm + 2 + stalls));
                check("busy_at_done", 64'(busy), 64'd0);
            end else if (traj_valid && !traj_ready) begin
                stalls++;
            end
            @(posedge CLK);
            #1;
            j++;
        end
        start = 1'b0;
        traj_ready = 1'b1;
        if (!got) begin
            chk_cnt++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected at %0d",
                     j, tm + 2 + stalls);
            do_reset();
        end
        if (mode == 2) check("stall_cycles", 64'(stalls), 64'd3);
        check("stream_len", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_mid_run();
        int j;
        push_expect(18'h20000, {CH{16'h8000}}, 5);
        mu = 18'h20000; x0 = {CH{16'h8000}}; times = 9'd5; start = 1'b1;
        traj_ready = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        j = 0;
        while (traj_step != 2 && j < 50) begin
            @(posedge CLK);
            #1 j++;
        end
        if (j >= 50) begin
            chk_cnt++;
            $display("FAIL step2_timeout: got step %0d, expected 2", traj_step);
        end
        #2 RST = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(traj_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_data", traj_data, 64'd0);
        check("rst_step", 64'(traj_step), 64'd0);
        exp_q.delete();
        res_q.delete();
        repeat (2) begin
            @(negedge CLK);
            check("no_done_in_reset", 64'(done), 64'd0);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; traj_ready = 1'b1;
        mu = '0; x0 = '0; times = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(traj_valid), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_data", traj_data, 64'd0);
        check("reset_step", 64'(traj_step), 64'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;

        run(18'h20000, {CH{16'h8000}}, 5, 0, 1'b0);
        run(18'h30000, {16'h0, 16'h0, 16'h0, 16'h8000}, 2, 0, 1'b0);
        run(18'h30000, {CH{16'h1234}}, 0, 0, 1'b0);
        run(18'h30000, {CH{16'h8000}}, 3, 2, 1'b0);
        run(18'h30000, {CH{16'h8000}}, 3, 0, 1'b1);
        // Back-to-back: accepted in the cycle after done.
        run(18'h38000, {16'h0, 16'hFFFF, 16'h0001, 16'h4000}, 4, 0, 1'b0);
        run(18'h00000, {$urandom, $urandom}, 3, 0, 1'b0);

        reset_mid_run();
        run(18'h20000, {CH{16'h8000}}, 5, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            run((W+2)'($urandom_range(0, 32'h3FFFF)), {$urandom, $urandom},
                int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1'($urandom));
        end

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/logistic_multi_iter.md
# logistic_multi_iter

Parametrised multi-channel logistic-map iterator: runs CH independent orbits x(n+1) = mu·x(n)·(1−x(n)) in unsigned fixed point under a start/done handshake. Every intermediate sample is streamed out over a valid/ready port with backpressure. It sits between the parameter/control logic and the pixel/plot logic of the chaos-map display. It supersedes the free-running single-orbit iterator with configurable precision, channel count, iteration count and a stall-safe trajectory stream.

## Interface
- W, 16: fraction bits; x is Q0.W, mu is Q2.W.
- CH, 4: number of parallel orbits sharing one mu.
- CNT_W, 9: width of iteration count and step index.
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- mu  in  W+2  map parameter, Q2.W, captured on accepted start.
- x0  in  CH*W  initial values, channel c at [c*W +: W], captured on accepted start.
- times  in  CNT_W  number of map applications, captured on accepted start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when final results are valid.
- result  out  CH*W  final x(times) per channel; held until next accepted start.
- traj_valid  out  1  trajectory sample available.
- traj_ready  in  1  consumer accepts sample.
- traj_data  out  CH*W  current x(step), all channels.
- traj_step  out  CNT_W  index n of traj_data.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1. Captures mu, x0 and times. Sets the x registers to x0 and step to 0.
- RUN presents traj_valid=1, traj_data=x regs and traj_step=step.
- In RUN, a handshake (traj_valid & traj_ready) with step==times: result ← x regs, go to DONE.
- In RUN, a handshake with step<times: x ← f(x) for every channel, step ← step+1.
- In RUN, no handshake: all registers hold, and traj_data/traj_step stay stable.
- DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- start is ignored outside IDLE. Input changes after capture have no effect.
- Map arithmetic, per channel, fully combinational, one step per accepted cycle:
  - t = x·(2^W − x), 2W bits unsigned.
  - h = t[2W−1:W], giving x(1−x) in Q0.W.
  - p = mu·h, 2W+2 bits.
  - y = p[2W−1:W], truncated with no rounding.
- mu < 4 and h ≤ 0.25, so p[2W+1:2W] is always 0. No saturation is needed.
- Edge values: x=0 gives y=0, and mu=0 gives y=0.
- times=0: a single sample (step 0 = x0) is streamed, and result = x0.
- The stream carries exactly times+1 samples per run, in order, with none dropped or duplicated.

## Timing
- Reset (RST=0, asynchronous) forces:
  - state IDLE;
  - busy=0, done=0, traj_valid=0;
  - result=0, traj_data=0, traj_step=0.
- Reset mid-run aborts immediately; no done is produced.
- All outputs are registered or decoded from the registered state.
- With start accepted at edge k:
  - busy=1 and traj_valid=1 from cycle k+1.
  - If traj_ready is held high, step n is presented in cycle k+1+n.
  - done=1 and result valid in cycle k+times+2.
  - busy=0 in cycle k+times+2, and IDLE in cycle k+times+3.
  - The earliest next start is accepted in cycle k+times+3.
- Each cycle with traj_ready=0 in RUN adds exactly one cycle to the latency.
- While traj_valid=1 and traj_ready=0, traj_data and traj_step must not change.

## Test plan
- W=16, CH=4, mu=0x20000 (2.0), all x0=0x8000, times=5, traj_ready=1 → six samples, each 0x8000, traj_step 0..5. done in cycle 7 after start, result all 0x8000.
- mu=0x30000 (3.0), channel0 x0=0x8000, times=2 → samples 0x8000, 0xC000, 0x9000. result ch0=0x9000. Other channels with x0=0 stay 0.
- times=0, x0=0x1234 → exactly one sample (step 0, 0x1234), done on the second cycle after start, result=0x1234.
- mu=0x30000, x0=0x8000, times=3, traj_ready low for 3 cycles at step 1 → traj_data held at 0xC000 and step held at 1 throughout the stall. done 3 cycles later than the unstalled run, same final result.
- start pulsed during RUN with different x0 → ignored, and the run completes with the originally captured values. A start in the cycle after DONE is accepted.
- RST asserted mid-run at step 2 → all outputs 0 asynchronously and no done. After release, a fresh start behaves as in the first scenario.
